vector_sequencer: RTL and testbench
===================================

// Module: vector_sequencer
// PURPOSE
//  Hardware replacement for file-driven stimulus: holds DEPTH input vectors,
//  drives them one at a time into a DataPath/Controller pair with a set/calc
//  handshake, and stores each result in an internal result memory.
//  Sits between the host load/readback interface and the DataPath under test.
//  Adds a programmable vector count, per-vector timeout and a sticky error flag.
// PARAMETERS
//  DATA_W   25   width of one input vector (dp_line)
//  RES_W    25   width of one DataPath result (dp_result)
//  DEPTH    64   entries in the input and result memories (power of 2)
//  AW       6    address width, log2(DEPTH)
//  TIMEOUT  255  max WAIT cycles per vector before forced completion (>=1)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous reset, active-low
//  load_we      in   1       write load_data into the input memory at load_addr
//  load_addr    in   AW      input memory write address
//  load_data    in   DATA_W  input vector to store
//  n_vec        in   AW+1    vectors per run; 0 means DEPTH; values >DEPTH clamp to DEPTH
//  start        in   1       1-cycle run request
//  busy         out  1       run in progress
//  done         out  1       1-cycle pulse at end of run
//  err_timeout  out  1       sticky: at least one vector timed out this run
//  dp_line      out  DATA_W  vector presented to DataPath
//  dp_set       out  1       1-cycle set strobe to DataPath/Controller
//  dp_calc      in   1       DataPath result-valid
//  dp_result    in   RES_W   DataPath result
//  res_addr     in   AW      result memory read address
//  res_data     out  RES_W   result memory read data, 1-cycle registered latency
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; busy, done, dp_set, err_timeout = 0;
//   dp_line = 0; res_data = 0; index and timeout counter = 0. Memory contents
//   are not cleared. Reset mid-run aborts at once; no done pulse.
//  FSM: IDLE -> ISSUE -> WAIT -> (ISSUE | FINISH) -> IDLE.
//   IDLE: start=1 -> ISSUE; index <= 0; err_timeout <= 0; run length latched
//    from n_vec. load_we honoured only in IDLE; ignored while busy.
//   ISSUE (1 cycle): dp_line <= in_mem[index]; dp_set = 1; tcnt <= 0.
//   WAIT: dp_set = 0; dp_line held. Each cycle:
//    dp_calc=1 -> res_mem[index] <= dp_result; advance.
//    else tcnt==TIMEOUT-1 -> res_mem[index] <= all-ones; err_timeout <= 1;
//     advance. else tcnt++.
//    advance: index==len-1 -> FINISH, else index++ and -> ISSUE.
//    dp_calc is ignored outside WAIT, including the ISSUE cycle.
//   FINISH (1 cycle): done = 1; -> IDLE.
//  busy = 1 in ISSUE, WAIT and FINISH.
//  start while busy is ignored; start and done in the same cycle starts nothing.
//  Per vector: 1 ISSUE cycle + k WAIT cycles, where 1 <= k <= TIMEOUT.
//   Minimum run time is 2*len + 1 cycles after the start edge.
//  Result read: res_data <= res_mem[res_addr] every cycle, in any state.
//   A read and a write to the same address in one cycle returns old data.
//  Indices wrap nowhere: the run stops at len-1. n_vec=0 or n_vec>=DEPTH
//   runs all DEPTH entries.
//  err_timeout holds until the next accepted start or reset.
// TESTING
//  1 load 4 vectors, n_vec=4, DataPath model asserts calc 3 cycles after set
//    -> 4 dp_set pulses 4 cycles apart; done 17 cycles after start;
//    res_mem[0..3] match the model; err_timeout=0.
//  2 n_vec=0, calc returned 1 cycle after set -> 64 vectors processed;
//    done at start+129; res_mem[63] written.
//  3 vector 2 never asserts calc, TIMEOUT=255 -> res_mem[2] = 25'h1FF_FFFF;
//    err_timeout=1; run completes; the next start clears err_timeout.
//  4 start and load_we pulsed mid-run -> run unaffected; in_mem unchanged;
//    only one done pulse.
//  5 rst=0 during WAIT of vector 5 -> busy, dp_set, dp_line = 0 at once;
//    a fresh start replays from vector 0.
//  6 read res_addr=3 while vector 3 is written -> old value; new value on the
//    following read.

Source files
------------

// File: rtl/vector_sequencer.sv
// -----------------------------------------------------------------------------
// vector_sequencer
//
// Replays up to DEPTH stored input vectors into a DataPath/Controller pair,
// one vector at a time, and captures each result in an internal result memory.
// A host fills the input memory while idle, pulses start, and reads results
// back through a registered read port.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   load_we      write load_data to in_mem[load_addr] (honoured only when idle)
//   load_addr    input memory write address
//   load_data    input vector to store
//   n_vec        vectors per run; 0 or >= DEPTH runs all DEPTH entries
//   start        1-cycle run request (ignored while busy)
//   busy         run in progress (ISSUE, WAIT, FINISH)
//   done         1-cycle pulse at end of run
//   err_timeout  sticky: some vector of this run timed out
//   dp_line      vector presented to the DataPath
//   dp_set       1-cycle set strobe to the DataPath/Controller
//   dp_calc      DataPath result-valid
//   dp_result    DataPath result
//   res_addr     result memory read address
//   res_data     result memory read data, one cycle after res_addr
//   dbg_state    current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 FINISH)
//
// Set/calc handshake: dp_set pulses for exactly one cycle (ISSUE); dp_line is
// loaded at the end of that cycle and held through WAIT. dp_calc is only looked
// at in WAIT; the first WAIT cycle with dp_calc=1 captures dp_result. If no
// dp_calc arrives within TIMEOUT WAIT cycles the vector is closed with an
// all-ones result and err_timeout is set. There is no backpressure.
// -----------------------------------------------------------------------------
module vector_sequencer #(
    parameter int DATA_W  = 25,
    parameter int RES_W   = 25,
    parameter int DEPTH   = 64,
    parameter int AW      = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [AW:0]       n_vec,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [DATA_W-1:0] dp_line,
    output logic              dp_set,
    input  logic              dp_calc,
    input  logic [RES_W-1:0]  dp_result,
    input  logic [AW-1:0]     res_addr,
    output logic [RES_W-1:0]  res_data,
    output logic [1:0]        dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [AW-1:0]       last_q, last_d;      // run length minus one
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   line_q, line_d;
    logic [RES_W-1:0]    res_data_q;

    logic [DATA_W-1:0]   in_mem  [DEPTH];
    logic [RES_W-1:0]    res_mem [DEPTH];

    logic                in_we;
    logic                res_we;
    logic [RES_W-1:0]    res_wdata;
    logic                timed_out;

    assign timed_out = (tcnt_q == TW'(TIMEOUT - 1));

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        tcnt_d    = tcnt_q;
        err_d     = err_q;
        line_d    = line_q;
        in_we     = 1'b0;
        res_we    = 1'b0;
        res_wdata = '0;

        case (state_q)
            S_IDLE: begin
                in_we = load_we;
                if (start) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    // n_vec == DEPTH truncates to 0 and wraps to all-ones,
                    // so only 0 and values above DEPTH need forcing.
                    if (n_vec == '0 || n_vec >= (AW+1)'(DEPTH))
                        last_d = '1;
                    else
                        last_d = n_vec[AW-1:0] - AW'(1);
                end
            end
            S_ISSUE: begin
                line_d  = in_mem[idx_q];
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dp_calc || timed_out) begin
                    res_we    = 1'b1;
                    res_wdata = dp_calc ? dp_result : '1;
                    if (!dp_calc)
                        err_d = 1'b1;
                    if (idx_q == last_q) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_ISSUE;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            tcnt_q     <= '0;
            err_q      <= 1'b0;
            line_q     <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            tcnt_q     <= tcnt_d;
            err_q      <= err_d;
            line_q     <= line_d;
            // Read-before-write: same-address write this cycle returns old data.
            res_data_q <= res_mem[res_addr];
        end
    end

    // Memories keep their contents across reset.
    always_ff @(posedge clk) begin
        if (in_we)
            in_mem[load_addr] <= load_data;
        if (res_we)
            res_mem[idx_q] <= res_wdata;
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign dp_set      = (state_q == S_ISSUE);
    assign err_timeout = err_q;
    assign dp_line     = line_q;
    assign res_data    = res_data_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vector_sequencer.sv
module tb_vector_sequencer;

    localparam int DATA_W  = 25;
    localparam int RES_W   = 25;
    localparam int DEPTH   = 64;
    localparam int AW      = 6;
    localparam int TIMEOUT = 255;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              load_we;
    logic [AW-1:0]     load_addr;
    logic [DATA_W-1:0] load_data;
    logic [AW:0]       n_vec;
    logic              start;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic [DATA_W-1:0] dp_line;
    logic              dp_set;
    logic              dp_calc;
    logic [RES_W-1:0]  dp_result;
    logic [AW-1:0]     res_addr;
    logic [RES_W-1:0]  res_data;
    logic [1:0]        dbg_state;

    vector_sequencer #(
        .DATA_W(DATA_W), .RES_W(RES_W), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .n_vec(n_vec), .start(start),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .dp_line(dp_line), .dp_set(dp_set), .dp_calc(dp_calc), .dp_result(dp_result),
        .res_addr(res_addr), .res_data(res_data), .dbg_state(dbg_state)
    );

    // ---------------- reference model state ----------------
    int total;
    int bad;
    int run_id;
    bit noise;                              // drive junk calc during the set cycle
    int lat_tab [DEPTH];                    // cycles from set to calc; 0 = never
    logic [DATA_W-1:0] in_model  [DEPTH];
    logic [RES_W-1:0]  res_model [DEPTH];
    int exp_set [DEPTH];
    int exp_done;
    logic [RES_W-1:0] exp_q[$];

    // observations from the last run
    int set_cyc [128];
    int n_sets, n_done, done_cyc, line_bad;
    logic [RES_W-1:0] hist [2048];
    logic [RES_W-1:0] rd_val [DEPTH];

    // ---------------- DataPath responder ----------------
    initial begin : responder
        int cd;
        int vcnt;
        int last_id;
        cd = 0; vcnt = 0; last_id = 0;
        dp_calc = 1'b0;
        dp_result = '0;
        forever begin
            @(posedge clk); #1;
            dp_calc = 1'b0;
            if (run_id != last_id) begin
                last_id = run_id; cd = 0; vcnt = 0;
            end
            if (dp_set === 1'b1) begin
                cd = (vcnt < DEPTH) ? lat_tab[vcnt] : 0;
                vcnt++;
                if (noise) begin
                    dp_calc = 1'b1;
                    dp_result = RES_W'($urandom);
                end
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    dp_calc = 1'b1;
                    dp_result = RES_W'(dp_line + DATA_W'(7));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic int k_of(input int lat);
        return (lat == 0) ? TIMEOUT : lat;
    endfunction

    // Expected timing and results of a run of len vectors, from the rules:
    // each vector costs 1 set cycle plus k wait cycles; done one cycle later.
    task automatic model_run(input int len);
        int t;
        logic [RES_W-1:0] r;
        t = 1;
        for (int i = 0; i < len; i++) begin
            exp_set[i] = t;
            r = (lat_tab[i] == 0) ? {RES_W{1'b1}} : RES_W'(in_model[i] + DATA_W'(7));
            res_model[i] = r;
            exp_q.push_back(r);
            t += 1 + k_of(lat_tab[i]);
        end
        exp_done = t;
    endtask

    task automatic load_vecs(input int n);
        for (int i = 0; i < n; i++) begin
            load_we = 1'b1;
            load_addr = AW'(i);
            load_data = DATA_W'($urandom);
            in_model[i] = load_data;
            @(posedge clk); #1;
        end
        load_we = 1'b0;
    endtask

    task automatic read_all(input int n);
        for (int i = 0; i < n; i++) begin
            res_addr = AW'(i);
            @(posedge clk); #1;
            rd_val[i] = res_data;
        end
    endtask

    // Pulse start, then observe limit cycles. At cycle poke_cyc a start and a
    // load_we pulse are injected.
    task automatic watch(input int limit, input int poke_cyc, input int probe);
        bit prev_set;
        n_sets = 0; n_done = 0; done_cyc = -1; line_bad = 0;
        res_addr = AW'(probe);
        run_id++;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        prev_set = 1'b0;
        for (int t = 1; t <= limit; t++) begin
            if (prev_set && n_sets > 0 && n_sets <= DEPTH && dp_line !== in_model[n_sets-1])
                line_bad++;
            if (dp_set === 1'b1) begin
                if (n_sets < 128) set_cyc[n_sets] = t;
                n_sets++;
            end
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = t;
            end
            if (t < 2048) hist[t] = res_data;
            prev_set = (dp_set === 1'b1);
            start   = (t == poke_cyc);
            load_we = (t == poke_cyc);
            if (t == poke_cyc) begin
                load_addr = AW'($urandom_range(0, 5));
                load_data = DATA_W'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        load_we = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        load_we = 0; load_addr = '0; load_data = '0; n_vec = '0; start = 0; res_addr = '0;
        noise = 0; run_id = 0;
        #2 rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (dp_set !== 1'b0) begin bad++; $display("FAIL reset_dp_set got=%b exp=0", dp_set); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
        total++; if (dp_line !== '0) begin bad++; $display("FAIL reset_dp_line got=%h exp=0", dp_line); end
        total++; if (res_data !== '0) begin bad++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic;
        load_vecs(4);
        for (int i = 0; i < 4; i++) lat_tab[i] = 3;
        noise = 1; n_vec = 7'd4;
        exp_q.delete(); model_run(4);
        watch(exp_done + 3, -1, 0);
        total++; if (n_sets !== 4) begin bad++; $display("FAIL basic_sets got=%0d exp=4", n_sets); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (set_cyc[i] !== exp_set[i]) begin bad++; $display("FAIL basic_set_cyc[%0d] got=%0d exp=%0d", i, set_cyc[i], exp_set[i]); end
        end
        total++; if (done_cyc !== exp_done) begin bad++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc, exp_done); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", n_done); end
        total++; if (line_bad !== 0) begin bad++; $display("FAIL basic_dp_line got=%0d exp=0 bad lines", line_bad); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err_timeout); end
        read_all(4);
        for (int i = 0; i < 4; i++) begin
            logic [RES_W-1:0] e;
            e = exp_q.pop_front();
            total++; if (rd_val[i] !== e) begin bad++; $display("FAIL basic_res[%0d] got=%h exp=%h", i, rd_val[i], e); end
        end
    endtask

    task automatic test_read_during_write;
        logic [RES_W-1:0] old3;
        int tw;
        old3 = res_model[3];
        load_vecs(6);
        for (int i = 0; i < 6; i++) lat_tab[i] = 2;
        noise = 0; n_vec = 7'd5;
        exp_q.delete(); model_run(5);
        watch(exp_done + 3, -1, 3);
        tw = exp_set[3] + k_of(lat_tab[3]);
        total++; if (hist[tw+1] !== old3) begin bad++; $display("FAIL rdw_old got=%h exp=%h", hist[tw+1], old3); end
        total++; if (hist[tw+2] !== res_model[3]) begin bad++; $display("FAIL rdw_new got=%h exp=%h", hist[tw+2], res_model[3]); end
        total++; if (done_cyc !== exp_done) begin bad++; $display("FAIL rdw_done_cyc got=%0d exp=%0d", done_cyc, exp_done); end
        exp_q.delete();
    endtask

    task automatic test_full;
        load_vecs(DEPTH);
        for (int i = 0; i < DEPTH; i++) lat_tab[i] = 1;
        noise = 1; n_vec = '0;
        exp_q.delete(); model_run(DEPTH);
        watch(exp_done + 3, -1, 0);
        total++; if (n_sets !== DEPTH) begin bad++; $display("FAIL full_sets got=%0d exp=%0d", n_sets, DEPTH); end
        total++; if (done_cyc !== exp_done) begin bad++; $display("FAIL full_done_cyc got=%0d exp=%0d", done_cyc, exp_done); end
        total++; if (line_bad !== 0) begin bad++; $display("FAIL full_dp_line got=%0d exp=0 bad lines", line_bad); end
        read_all(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            logic [RES_W-1:0] e;
            e = exp_q.pop_front();
            total++; if (rd_val[i] !== e) begin bad++; $display("FAIL full_res[%0d] got=%h exp=%h", i, rd_val[i], e); end
        end
    endtask

    task automatic test_clamp;
        load_vecs(DEPTH);
        for (int i = 0; i < DEPTH; i++) lat_tab[i] = $urandom_range(1, 4);
        noise = 0; n_vec = (AW+1)'($urandom_range(DEPTH + 1, 2*DEPTH - 1));
        exp_q.delete(); model_run(DEPTH);
        watch(exp_done + 3, -1, 0);
        total++; if (n_sets !== DEPTH) begin bad++; $display("FAIL clamp_sets n_vec=%0d got=%0d exp=%0d", n_vec, n_sets, DEPTH); end
        total++; if (done_cyc !== exp_done) begin bad++; $display("FAIL clamp_done_cyc got=%0d exp=%0d", done_cyc, exp_done); end
        read_all(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            logic [RES_W-1:0] e;
            e = exp_q.pop_front();
            total++; if (rd_val[i] !== e) begin bad++; $display("FAIL clamp_res[%0d] got=%h exp=%h", i, rd_val[i], e); end
        end
    endtask

    task automatic test_random_runs;
        for (int r = 0; r < 3; r++) begin
            int len;
            bit any_to;
            len = $urandom_range(1, 12);
            load_vecs(len);
            any_to = 0;
            for (int i = 0; i < len; i++) begin
                lat_tab[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
                if (lat_tab[i] == 0) any_to = 1;
            end
            noise = bit'($urandom_range(0, 1)); n_vec = (AW+1)'(len);
            exp_q.delete(); model_run(len);
            watch(exp_done + 3, -1, 0);
            total++; if (n_sets !== len) begin bad++; $display("FAIL rand_sets got=%0d exp=%0d", n_sets, len); end
            total++; if (done_cyc !== exp_done) begin bad++; $display("FAIL rand_done_cyc got=%0d exp=%0d", done_cyc, exp_done); end
            total++; if (err_timeout !== any_to) begin bad++; $display("FAIL rand_err got=%b exp=%b", err_timeout, any_to); end
            read_all(len);
            for (int i = 0; i < len; i++) begin
                logic [RES_W-1:0] e;
                e = exp_q.pop_front();
                total++; if (rd_val[i] !== e) begin bad++; $display("FAIL rand_res[%0d] got=%h exp=%h", i, rd_val[i], e); end
            end
        end
    endtask

    task automatic test_timeout;
        load_vecs(4);
        lat_tab[0] = 2; lat_tab[1] = 3; lat_tab[2] = 0; lat_tab[3] = 1;
        noise = 0; n_vec = 7'd4;
        exp_q.delete(); model_run(4);
        watch(exp_done + 3, -1, 0);
        total++; if (done_cyc !== exp_done) begin bad++; $display("FAIL to_done_cyc got=%0d exp=%0d", done_cyc, exp_done); end
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", err_timeout); end
        read_all(4);
        for (int i = 0; i < 4; i++) begin
            logic [RES_W-1:0] e;
            e = exp_q.pop_front();
            total++; if (rd_val[i] !== e) begin bad++; $display("FAIL to_res[%0d] got=%h exp=%h", i, rd_val[i], e); end
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err_sticky got=%b exp=1", err_timeout); end
        lat_tab[0] = 1; n_vec = 7'd1;
        exp_q.delete(); model_run(1);
        watch(exp_done + 3, -1, 0);
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_err_clear got=%b exp=0", err_timeout); end
        exp_q.delete();
    endtask

    task automatic test_midrun_pokes;
        load_vecs(6);
        for (int i = 0; i < 6; i++) lat_tab[i] = $urandom_range(2, 5);
        noise = 0; n_vec = 7'd6;
        exp_q.delete(); model_run(6);
        watch(exp_done + 15, 5, 0);
        total++; if (n_done !== 1) begin bad++; $display("FAIL mid_done_cnt got=%0d exp=1", n_done); end
        total++; if (done_cyc !== exp_done) begin bad++; $display("FAIL mid_done_cyc got=%0d exp=%0d", done_cyc, exp_done); end
        total++; if (n_sets !== 6) begin bad++; $display("FAIL mid_sets got=%0d exp=6", n_sets); end
        // Second run: in_mem must be untouched; start lands on the done cycle.
        exp_q.delete(); model_run(6);
        watch(exp_done + 15, exp_done, 0);
        total++; if (line_bad !== 0) begin bad++; $display("FAIL mid_in_mem got=%0d exp=0 bad lines", line_bad); end
        total++; if (n_sets !== 6) begin bad++; $display("FAIL mid_start_at_done got=%0d exp=6 sets", n_sets); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_idle_after got=%b exp=0", busy); end
        read_all(6);
        for (int i = 0; i < 6; i++) begin
            logic [RES_W-1:0] e;
            e = exp_q.pop_front();
            total++; if (rd_val[i] !== e) begin bad++; $display("FAIL mid_res[%0d] got=%h exp=%h", i, rd_val[i], e); end
        end
    endtask

    task automatic test_reset_midrun;
        load_vecs(8);
        for (int i = 0; i < 8; i++) lat_tab[i] = $urandom_range(2, 4);
        noise = 0; n_vec = 7'd8;
        exp_q.delete(); model_run(8);
        watch(exp_set[5], -1, 0);   // returns in the first WAIT cycle of vector 5
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        total++; if (n_done !== 0) begin bad++; $display("FAIL rstmid_early_done got=%0d exp=0", n_done); end
        #2 rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (dp_set !== 1'b0) begin bad++; $display("FAIL rstmid_dp_set got=%b exp=0", dp_set); end
        total++; if (dp_line !== '0) begin bad++; $display("FAIL rstmid_dp_line got=%h exp=0", dp_line); end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
        exp_q.delete(); model_run(8);
        watch(exp_done + 3, -1, 0);
        total++; if (set_cyc[0] !== 1) begin bad++; $display("FAIL rstmid_restart got=%0d exp=1", set_cyc[0]); end
        total++; if (line_bad !== 0) begin bad++; $display("FAIL rstmid_replay got=%0d exp=0 bad lines", line_bad); end
        total++; if (done_cyc !== exp_done) begin bad++; $display("FAIL rstmid_done_cyc got=%0d exp=%0d", done_cyc, exp_done); end
        read_all(8);
        for (int i = 0; i < 8; i++) begin
            logic [RES_W-1:0] e;
            e = exp_q.pop_front();
            total++; if (rd_val[i] !== e) begin bad++; $display("FAIL rstmid_res[%0d] got=%h exp=%h", i, rd_val[i], e); end
        end
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        total = 0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            lat_tab[i] = 1; in_model[i] = '0; res_model[i] = '0;
        end
        test_reset();
        test_basic();
        test_read_during_write();
        test_full();
        test_clamp();
        test_random_runs();
        test_timeout();
        test_midrun_pokes();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
